// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants for the instruction-fetch stage: FSM encodings,
// the NOP word, the instruction width and the default reset PC.
package fetch_unit_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DROP  = 3'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect / increment / hold select.
// Redirect targets are word-aligned by clearing the low two bits.
module fetch_pc_reg #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            advance,
    output logic [PC_W-1:0] pc
);

    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_next_s;

    // Next-PC select: a redirect beats the sequential increment
    always_comb begin
        pc_next_s = pc_r;
        if (redirect_valid) begin
            pc_next_s = align_word(redirect_pc);
        end else if (advance) begin
            pc_next_s = pc_r + PC_W'(4);
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register: one outstanding imem request,
// stall hold buffer, redirect with stale-response drop. Optional FETCH_MISALIGN_EN adds misalign_err.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               if_id_we,
    output logic               if_id_flush
`ifdef FETCH_MISALIGN_EN
    ,
    output logic               misalign_err
`endif
);

    logic [2:0]         state_r;
    logic [2:0]         state_next_s;
    logic [INSTR_W-1:0] hold_buf_r;
    logic               hold_load_s;
    logic               pc_advance_s;
    logic [PC_W-1:0]    pc_s;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (pc_advance_s),
        .pc             (pc_s)
    );

    assign imem_addr = pc_s;

    // FSM next-state and IF/ID output mux; redirect dominates stall and rvalid
    always_comb begin
        state_next_s = state_r;
        imem_req     = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        pc_out       = '0;
        instr_out    = NOP_WORD;
        hold_load_s  = 1'b0;
        pc_advance_s = 1'b0;
        case (state_r)
            ST_RESET: begin
                state_next_s = ST_REQ;
            end
            ST_REQ: begin
                imem_req = !redirect_valid;
                if (redirect_valid) begin
                    if_id_flush  = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    if_id_flush  = !stall;
                    state_next_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    if_id_flush  = 1'b1;
                    state_next_s = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid && !stall) begin
                    if_id_we     = 1'b1;
                    instr_out    = imem_rdata;
                    pc_out       = pc_s + PC_W'(4);
                    pc_advance_s = 1'b1;
                    state_next_s = ST_REQ;
                end else if (imem_rvalid) begin
                    hold_load_s  = 1'b1;
                    state_next_s = ST_HOLD;
                end else begin
                    if_id_flush  = !stall;
                    state_next_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    if_id_flush  = 1'b1;
                    state_next_s = ST_REQ;
                end else if (!stall) begin
                    if_id_we     = 1'b1;
                    instr_out    = hold_buf_r;
                    pc_out       = pc_s + PC_W'(4);
                    pc_advance_s = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                // Only one request is ever outstanding, so its response ends the drop
                if_id_flush  = redirect_valid || !stall;
                state_next_s = imem_rvalid ? ST_REQ : ST_DROP;
            end
            default: begin
                state_next_s = ST_RESET;
            end
        endcase
    end

    // FSM state and stall hold buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RESET;
            hold_buf_r <= NOP_WORD;
        end else begin
            state_r <= state_next_s;
            if (hold_load_s) begin
                hold_buf_r <= imem_rdata;
            end
        end
    end

`ifdef FETCH_MISALIGN_EN
    logic misalign_r;

    // One-cycle flag for a redirect target that was not word-aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_err = misalign_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs change on the falling edge
// and the combinational outputs are sampled 1 time unit later.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        if_id_we;
    logic        if_id_flush;
`ifdef FETCH_MISALIGN_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .if_id_we       (if_id_we),
        .if_id_flush    (if_id_flush)
`ifdef FETCH_MISALIGN_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic st, input logic rv, input logic [31:0] rdata,
                         input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        stall          = st;
        imem_rvalid    = rv;
        imem_rdata     = rdata;
        redirect_valid = rd;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (if_id_we !== 1'b0 || if_id_flush !== 1'b0) begin errors++; $display("FAIL rst_ctl got we=%b fl=%b exp 0/0", if_id_we, if_id_flush); end
        checks++; if (pc_out !== 32'h0 || instr_out !== 32'h0) begin errors++; $display("FAIL rst_data got pc=%h in=%h exp 0/0", pc_out, instr_out); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || if_id_flush !== 1'b0 || if_id_we !== 1'b0) begin errors++; $display("FAIL reset_state_ctl got req=%b fl=%b we=%b exp 0/0/0", imem_req, if_id_flush, if_id_we); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_req%0d got req=%b addr=%h exp 1/%h", k, imem_req, imem_addr, 32'(4 * k)); end
            checks++; if (if_id_flush !== 1'b1 || if_id_we !== 1'b0) begin errors++; $display("FAIL seq_bubble%0d got fl=%b we=%b exp 1/0", k, if_id_flush, if_id_we); end
            drive(1'b0, 1'b1, 32'hA000_0000 + 32'(k), 1'b0, 32'h0);
            checks++; if (if_id_we !== 1'b1 || if_id_flush !== 1'b0) begin errors++; $display("FAIL seq_we%0d got we=%b fl=%b exp 1/0", k, if_id_we, if_id_flush); end
            checks++; if (pc_out !== 32'(4 * k + 4) || instr_out !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL seq_data%0d got pc=%h in=%h exp %h/%h", k, pc_out, instr_out, 32'(4 * k + 4), 32'hA000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h0000_000C) begin errors++; $display("FAIL stall_addr got %h exp 0000000c", imem_addr); end
        drive(1'b1, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0);
        checks++; if (if_id_we !== 1'b0 || if_id_flush !== 1'b0) begin errors++; $display("FAIL stall_c0 got we=%b fl=%b exp 0/0", if_id_we, if_id_flush); end
        for (int c = 1; c < 3; c++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            checks++; if (if_id_we !== 1'b0 || if_id_flush !== 1'b0) begin errors++; $display("FAIL stall_c%0d got we=%b fl=%b exp 0/0", c, if_id_we, if_id_flush); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (if_id_we !== 1'b1 || instr_out !== 32'hCAFE_0001 || pc_out !== 32'h0000_0010) begin errors++; $display("FAIL stall_release got we=%b in=%h pc=%h exp 1/cafe0001/00000010", if_id_we, instr_out, pc_out); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0010) begin errors++; $display("FAIL stall_next_addr got req=%b addr=%h exp 1/00000010", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
        checks++; if (if_id_flush !== 1'b1 || if_id_we !== 1'b0) begin errors++; $display("FAIL rdw_flush got fl=%b we=%b exp 1/0", if_id_flush, if_id_we); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (if_id_flush !== 1'b1 || if_id_we !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rdw_drop got fl=%b we=%b req=%b exp 1/0/0", if_id_flush, if_id_we, imem_req); end
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        checks++; if (if_id_we !== 1'b0 || if_id_flush !== 1'b1) begin errors++; $display("FAIL rdw_stale got we=%b fl=%b exp 0/1", if_id_we, if_id_flush); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rdw_target got req=%b addr=%h exp 1/00000100", imem_req, imem_addr); end
        drive(1'b0, 1'b1, 32'h1111_2222, 1'b0, 32'h0);
        checks++; if (if_id_we !== 1'b1 || pc_out !== 32'h0000_0104 || instr_out !== 32'h1111_2222) begin errors++; $display("FAIL rdw_deliver got we=%b pc=%h in=%h exp 1/00000104/11112222", if_id_we, pc_out, instr_out); end
    endtask

    task automatic test_redirect_rvalid_stall();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h0000_0104) begin errors++; $display("FAIL rrs_addr got %h exp 00000104", imem_addr); end
        drive(1'b1, 1'b1, 32'h5555_AAAA, 1'b1, 32'h0000_0200);
        checks++; if (if_id_flush !== 1'b1 || if_id_we !== 1'b0) begin errors++; $display("FAIL rrs_flush got fl=%b we=%b exp 1/0", if_id_flush, if_id_we); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL rrs_target got req=%b addr=%h exp 1/00000200", imem_req, imem_addr); end
        drive(1'b0, 1'b1, 32'h7777_0000, 1'b0, 32'h0);
        checks++; if (if_id_we !== 1'b1 || pc_out !== 32'h0000_0204) begin errors++; $display("FAIL rrs_deliver got we=%b pc=%h exp 1/00000204", if_id_we, pc_out); end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        checks++; if (imem_req !== 1'b0 || if_id_flush !== 1'b1) begin errors++; $display("FAIL wrap_redir got req=%b fl=%b exp 0/1", imem_req, if_id_flush); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got req=%b addr=%h exp 1/fffffffc", imem_req, imem_addr); end
        drive(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0);
        checks++; if (if_id_we !== 1'b1 || pc_out !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pcout got we=%b pc=%h exp 1/00000000", if_id_we, pc_out); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next got %h exp 00000000", imem_addr); end
    endtask

    task automatic test_misalign();
        drive(1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0203);
        checks++; if (if_id_flush !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL mis_redir got fl=%b req=%b exp 1/0", if_id_flush, imem_req); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL mis_addr got %h exp 00000200", imem_addr); end
`ifdef FETCH_MISALIGN_EN
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", misalign_err); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", misalign_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid_stall();
        test_wrap();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC, issues one request at a time to instruction memory, and accepts branch/jump redirects from EX.
- Honours stall from the hazard unit.
- Drives the IF/ID load enable (IF_ID_sel), the IF/ID flush, and the pcregin/instructin data.
- pc_out is PC+4 of the delivered instruction, as ID/EX branch arithmetic expects.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_W, 32, PC and address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- stall  in  1  hazard unit: hold IF and IF/ID.
- redirect_valid  in  1  EX resolved taken branch/jump this cycle.
- redirect_pc  in  PC_W  redirect target.
- imem_req  out  1  single-cycle fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_rvalid  in  1  response valid; at least 1 cycle after imem_req.
- imem_rdata  in  32  response instruction word.
- pc_out  out  PC_W  to IF/ID pcregin (pc+4).
- instr_out  out  32  to IF/ID instructin.
- if_id_we  out  1  to IF/ID IF_ID_sel.
- if_id_flush  out  1  to IF/ID flush.

Behaviour:
- State: RESET, REQ, WAIT, HOLD, DROP. Also registers pc, hold_buf[31:0].
- Reset (async, rst_n=0):
  - state=RESET, pc=RESET_PC, hold_buf=0.
  - Outputs: imem_req=0, if_id_we=0, if_id_flush=0, pc_out=0, instr_out=0.
- RESET: all control outputs 0. Next edge goes to REQ.
- REQ:
  - imem_req = !redirect_valid; imem_addr = pc.
  - Next state: WAIT if the request issued, else REQ.
- WAIT, imem_rvalid=1 and stall=0:
  - Deliver: instr_out=imem_rdata, pc_out=pc+4, if_id_we=1.
  - pc<=pc+4; next state REQ.
- WAIT, imem_rvalid=1 and stall=1:
  - hold_buf<=imem_rdata; next state HOLD.
- HOLD, stall=0:
  - Deliver hold_buf with pc_out=pc+4, if_id_we=1.
  - pc<=pc+4; next state REQ.
- Bubble: no instruction delivered, stall=0, no redirect → if_id_flush=1, if_id_we=0. IF/ID then loads a NOP.
- Stall: stall=1 → if_id_we=0 and if_id_flush=0. The PC does not advance.
- Redirect (highest priority; overrides stall and any coincident rvalid):
  - pc<=redirect_pc with bits[1:0] forced to 0.
  - if_id_flush=1 and if_id_we=0 in the same cycle.
  - Next state from REQ/HOLD/RESET: REQ, and hold_buf is discarded.
  - Next state from WAIT with no rvalid this cycle: DROP.
  - Next state from WAIT with rvalid this cycle: REQ; the response is dropped.
  - Next state from DROP: stays DROP; pc is updated.
- DROP:
  - Waits for the stale response, then discards it; no delivery.
  - On rvalid goes to REQ.
  - if_id_flush=1 unless stall=1.
- Timing: pc_out, instr_out, if_id_we, if_id_flush are combinational from state and inputs. IF/ID registers them.
- Best-case throughput: 1 instruction per 2 cycles (REQ + WAIT, memory latency 1).
- Arithmetic: pc+4 is modulo 2^PC_W; 32'hFFFF_FFFC + 4 wraps to 0.
- imem_rvalid outside WAIT/DROP is ignored.
- rst_n asserted mid-WAIT: the outstanding response after release is ignored, because RESET and REQ ignore rvalid.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- With the macro defined:
  - Adds output misalign_err (1 bit, reset 0).
  - misalign_err pulses for one cycle, registered, on the edge after a redirect with redirect_pc[1:0]!=0.
  - The PC is still aligned.
- Without the macro: no port; low bits are silently cleared.

Decomposition:
- Shared package (pipeline pkg):
  - Fetch state enum (RESET, REQ, WAIT, HOLD, DROP).
  - NOP word 32'h0.
  - Instruction-width constant.
  - RESET_PC default.
- Sub-module: fetch_pc_reg, holding the PC register with redirect/increment/hold select and alignment. It is reusable by a future BTB.
- The FSM and output muxing stay in fetch_unit.

Test Plan:
- Reset release, imem latency 1, stall=0 → imem_addr 0,4,8 on cycles 1,3,5. if_id_we pulses with pc_out 4,8,12 and instr_out equal to rdata; if_id_flush=1 on the REQ cycles.
- Response arrives with stall=1 for 3 cycles → if_id_we=0 and flush=0 for 3 cycles. The buffered word is delivered the cycle stall drops; pc advances exactly once.
- redirect_valid with target 0x100 during WAIT, rvalid 2 cycles later → flush=1 on redirect; stale word never delivered; next imem_addr=0x100.
- redirect_valid coincident with rvalid and stall=1 → flush=1, if_id_we=0, next request to target.
- pc=0xFFFF_FFFC fetched → pc_out=0, next imem_addr=0.
- With FETCH_MISALIGN_EN, redirect_pc=0x203 → next imem_addr=0x200 and a one-cycle misalign_err pulse. Without the macro → address 0x200, no port.
